// File: rtl/riscbee_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type
// and the access-size and legality decoders.
package riscbee_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Bytes touched by an access; 0 for the unused size code 11.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        if (write) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result merge: joins the one or two fetched words, shifts the addressed
// bytes down to bit 0 and applies sign or zero extension.
module lsu_load_align
    import riscbee_lsu_pkg::*;
(
    input  logic [31:0] first,
    input  logic [31:0] second,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic        split,
    output logic [31:0] result
);

    logic [63:0] pair;
    logic [31:0] merged;

    always_comb begin
        pair   = {(split ? second : 32'h0000_0000), first};
        merged = pair[{1'b0, off, 3'b000} +: 32];
        case (funct3)
            F3_B:    result = {{24{merged[7]}}, merged[7:0]};
            F3_BU:   result = {24'h000000, merged[7:0]};
            F3_H:    result = {{16{merged[15]}}, merged[15:0]};
            F3_HU:   result = {16'h0000, merged[15:0]};
            default: result = merged;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request in flight, word-crossing accesses are
// split into two memory cycles or rejected depending on ALLOW_MISALIGNED.
module load_store_unit
    import riscbee_lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_bytes,
    output logic        mem_write,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout,
    output lsu_state_e  fsm_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and every request field is
    // captured on that edge and never looked at again.

    lsu_state_e  state, state_next;
    logic        accept;
    logic        write_q, error_q, split_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, first_q, rdata_q;
    logic [2:0]  req_size;
    logic        req_split, req_error;
    logic [1:0]  off;
    logic [31:0] base_addr;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] store_shift;
    logic [31:0] align_first, load_result;
    logic        load_capture;

    always_comb begin
        req_size  = access_size(req_funct3);
        req_split = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
        req_error = !funct3_legal(req_write, req_funct3) || (req_split && !ALLOW_MISALIGNED);
    end

    assign accept    = req_valid && req_ready;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_ACC0;
            ST_ACC0: state_next = split_q ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte lanes and data for both halves come from one 8-lane / 64-bit view:
    // the low half feeds the first word, the high half the following word.
    always_comb begin
        off       = addr_q[1:0];
        base_addr = {addr_q[31:2], 2'b00};
        case (access_size(funct3_q))
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
        lane_mask   = {4'b0000, size_mask} << off;
        store_shift = {32'h0000_0000, wdata_q} << {off, 3'b000};
    end

    assign align_first  = (state == ST_ACC1) ? first_q : mem_dataout;
    assign load_capture = !write_q && !error_q &&
                          (((state == ST_ACC0) && !split_q) || (state == ST_ACC1));

    lsu_load_align u_load_align (
        .first  (align_first),
        .second (mem_dataout),
        .off    (off),
        .funct3 (funct3_q),
        .split  (split_q),
        .result (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= 1'b0;
            error_q  <= 1'b0;
            split_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            first_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                error_q  <= req_error;
                split_q  <= req_split && !req_error;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata_q  <= 32'h0;
            end
            if (state == ST_ACC0) begin
                first_q <= mem_dataout;
            end
            if (load_capture) begin
                rdata_q <= load_result;
            end
        end
    end

    // Everything is forced quiet while rst is high so that a reset landing in
    // ACC1 aborts the second half of a split store instead of writing it.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_error = 1'b0;
        mem_addr   = 32'h0;
        mem_bytes  = 4'b0000;
        mem_write  = 1'b0;
        mem_datain = 32'h0;
        if (!rst) begin
            case (state)
                ST_IDLE: req_ready = 1'b1;
                ST_ACC0: begin
                    mem_addr = base_addr;
                    if (write_q && !error_q) begin
                        mem_write  = 1'b1;
                        mem_bytes  = lane_mask[3:0];
                        mem_datain = store_shift[31:0];
                    end
                end
                ST_ACC1: begin
                    mem_addr = base_addr + 32'd4;
                    if (write_q) begin
                        mem_write  = 1'b1;
                        mem_bytes  = lane_mask[7:4];
                        mem_datain = store_shift[63:32];
                    end
                end
                ST_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_error = error_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ALLOW_MISALIGNED, default 1, meaning 1 = split word-crossing accesses into two memory cycles, 0 = reject them with an error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-012 resp_error  output  1  illegal funct3 or rejected misalignment, qualified by resp_valid.
REQ-013 mem_addr  output  32  word-aligned address to the data memory.
REQ-014 mem_bytes  output  4  byte-lane write enables; lane k is byte mem_addr+k.
REQ-015 mem_write  output  1  store strobe.
REQ-016 mem_datain  output  32  lane-aligned store data.
REQ-017 mem_dataout  input  32  combinational read data of the word at mem_addr.

Function
REQ-018 The handshake SHALL transfer on req_valid && req_ready, and req_ready SHALL be 1 only in IDLE.
REQ-019 The accept cycle SHALL register the request; no request input is sampled afterwards.
REQ-020 The FSM SHALL have states IDLE, ACC0, ACC1, RESP, with transitions IDLE->ACC0 on accept; ACC0->ACC1 if split, else ACC0->RESP; ACC1->RESP; RESP->IDLE.
REQ-021 Legal codes SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. All other codes are illegal.
REQ-022 Size N = 1/2/4 bytes and off = addr[1:0]; an access is split iff off+N > 4.
REQ-023 Illegal requests, and split requests when ALLOW_MISALIGNED=0, SHALL skip memory cycles (ACC0 drives mem_bytes=0) and go to RESP with resp_error=1.
REQ-024 In ACC0, mem_addr SHALL be {addr[31:2],00}. In ACC1, mem_addr SHALL be that value +4, mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-025 Store in ACC0: mem_write=1, lanes off..min(3,off+N-1) enabled, mem_datain = wdata << 8*off.
REQ-026 Store in ACC1: lanes 0..off+N-5 enabled, mem_datain = wdata >> 8*(4-off).
REQ-027 Loads SHALL drive mem_write=0 and mem_bytes=0000 in every state.
REQ-028 Load ACC0 SHALL register mem_dataout. The load result is (first >> 8*off) | (second << 8*(4-off)), with the second term only if split, then masked to N bytes. It is sign-extended for LB/LH and zero-extended for LBU/LHU/LW.
REQ-029 Outside ACC0/ACC1, mem_bytes SHALL be 0000, mem_write 0, mem_addr 0 and mem_datain 0.
REQ-030 In RESP, resp_valid=1 and resp_rdata/resp_error SHALL hold registered values; at all other times resp_valid=0, resp_rdata=0 and resp_error=0.
REQ-031 Latency: accept at cycle T gives resp_valid at T+2 for unsplit or error requests and at T+3 for split requests. The next accept is possible at the cycle after RESP.

Reset
REQ-032 While rst=1 at a clock edge, the state SHALL become IDLE and all registers SHALL clear. The outputs are then req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_bytes=0, mem_write=0, mem_addr=0, mem_datain=0.
REQ-033 Reset during ACC1 SHALL abort the access; the ACC0 half of a split store remains written (accepted partial store), and no response is produced.
REQ-034 A request presented during reset SHALL NOT be accepted.

Structure
REQ-035 The shared package riscbee_lsu_pkg SHALL hold the funct3 constants, the state enum and the size-decode function.
REQ-036 Sub-module lsu_load_align (combinational merge/shift/extend per REQ-028) SHALL be instantiated once.
REQ-037 The target size is 150-300 lines of RTL, with no memory array inside this block.

Verification
REQ-038 Store SW at 0x10, wdata 0xDEADBEEF -> ACC0: mem_addr 0x10, bytes 1111, datain 0xDEADBEEF; resp_valid at T+2, rdata 0.
REQ-039 Memory word 0x10 = 0x80FF7F01: LB at 0x13 -> 0xFFFFFF80; LBU at 0x13 -> 0x00000080; LH at 0x12 -> 0xFFFF80FF.
REQ-040 SW at 0x11, wdata 0xAABBCCDD, ALLOW_MISALIGNED=1 -> ACC0 bytes 1110, datain 0xBBCCDD00; ACC1 addr 0x14, bytes 0001, datain 0x000000AA; resp at T+3.
REQ-041 LW at 0xFFFFFFFE -> ACC1 mem_addr 0x00000000; result is the merge of upper 2 bytes of the top word and lower 2 bytes of word 0.
REQ-042 funct3=011 load, and a misaligned LH with ALLOW_MISALIGNED=0 -> no mem_bytes activity, resp_error=1, rdata 0 at T+2.
REQ-043 rst asserted in ACC1 of a split store -> next cycle IDLE and req_ready=1, no resp_valid, only the first-word lanes are written.
